uart_cmd_controller: RTL and testbench
======================================

# uart_cmd_controller

Command-level controller for the UART-to-flash datapath. It parses opcode, length and address bytes from the UART receiver and drives the one-hot `status` bus and `data_trans_length` consumed by the serial-port address generator. It also sequences the flash engine around each RAM transfer and returns to idle when the address generator raises `finish_flag`.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 24'd5_000_000: header inter-byte timeout; only used when the timeout feature is compiled in.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx_flag`  in  1  UART byte-valid level; a rising edge means `rx_data` holds a new byte.
- `rx_data`  in  8  received byte.
- `finish_flag`  in  1  one-cycle pulse from the address generator: RAM write or read pass complete.
- `flash_done`  in  1  one-cycle pulse from the flash engine: operation complete.
- `status`  out  8  one-hot state, using the shared State.v codes.
- `data_trans_length`  out  8  byte count for the RAM pass.
- `flash_addr`  out  16  flash page address, MSB received first.
- `flash_start`  out  1  one-cycle start pulse to the flash engine.
- `flash_wr`  out  1  1 = program, 0 = read; valid while `flash_start` is high.
- `busy`  out  1  high whenever `status` is not IDLE.
- `cmd_err`  out  1  one-cycle error pulse.

## Operation
- Byte detect: `rx_flag` is registered into `rx_flag_d`. A byte is accepted on the cycle where `rx_flag & ~rx_flag_d`.
- States and codes: IDLE 8'h01, GET_LEN 8'h02, GET_ADDR 8'h04, FLASH_READ 8'h08, WRITING_RAM 8'h10, READING_RAM 8'h20, FLASH_WRITE 8'h40, ERROR 8'h80.
- IDLE:
  - byte 8'h57 ('W') sets `op_wr` = 1 and goes to GET_LEN.
  - byte 8'h52 ('R') sets `op_wr` = 0 and goes to GET_LEN.
  - any other byte goes to ERROR.
- GET_LEN: the byte is latched into `data_trans_length`. A value of 0 goes to ERROR; otherwise go to GET_ADDR.
- GET_ADDR: two bytes are counted by a 1-bit byte counter. The first byte goes to `flash_addr[15:8]`, the second to `flash_addr[7:0]`. After the second byte:
  - if `op_wr` = 1, go to WRITING_RAM;
  - if `op_wr` = 0, go to FLASH_READ.
- WRITING_RAM: bytes are not parsed here; they belong to the address generator. `finish_flag` moves the state to FLASH_WRITE.
- FLASH_WRITE: `flash_start` pulses and `flash_wr` = 1. `flash_done` moves the state to IDLE.
- FLASH_READ: `flash_start` pulses and `flash_wr` = 0. `flash_done` moves the state to READING_RAM.
- READING_RAM: `finish_flag` moves the state to IDLE.
- ERROR: pulses `cmd_err` and returns to IDLE on the next cycle.
- Events outside their state are ignored:
  - `finish_flag` outside WRITING_RAM/READING_RAM;
  - `flash_done` outside FLASH_WRITE/FLASH_READ;
  - received bytes in any state other than IDLE, GET_LEN and GET_ADDR.
- Simultaneous `finish_flag` and `flash_done`: only the event valid in the current state acts.
- `data_trans_length` and `flash_addr` hold their values until overwritten by the next command.

## Timing
- Reset values:
  - `status` = 8'h01;
  - `data_trans_length`, `flash_addr` = 0;
  - `flash_start`, `flash_wr`, `busy`, `cmd_err` = 0;
  - internal byte counter and `rx_flag_d` = 0.
- Byte latency: if `rx_flag` rises before clock edge N, the byte is detected at edge N and `status` updates at edge N+1.
- `finish_flag`/`flash_done` latency: a pulse sampled at edge N changes `status` at edge N.
- `flash_start` is registered and high for exactly the first cycle in FLASH_WRITE or FLASH_READ. `flash_wr` holds from that cycle until the state is left.
- `cmd_err` is high exactly for the one cycle spent in ERROR.
- `busy` is derived from the registered `status` (`status != 8'h01`), so it has no extra latency.
- Reset asserted mid-command: all outputs return to reset values immediately. A partially received header is discarded.

## Configuration
- `UART_CMD_TIMEOUT_EN` defined:
  - a 24-bit counter runs in GET_LEN and GET_ADDR and clears on every accepted byte;
  - reaching `TIMEOUT_CYCLES` goes to ERROR, so `cmd_err` pulses and the block returns to IDLE.
- `UART_CMD_TIMEOUT_EN` undefined: no counter; header states wait indefinitely.

## Test plan
- Write command: bytes 57, 04, 12, 34, then 4 data bytes, then `finish_flag` pulse, then `flash_done` 10 cycles later.
  - Required: `status` steps 01→02→04→10→40→01; `data_trans_length` = 8'h04; `flash_addr` = 16'h1234; one `flash_start` pulse with `flash_wr` = 1.
- Read command: bytes 52, 10, 00, 80, then `flash_done`, then `finish_flag`.
  - Required: `status` steps 01→02→04→08→20→01; one `flash_start` pulse with `flash_wr` = 0.
- Bad input, two cases:
  - opcode 8'hAA: `cmd_err` one-cycle pulse, `status` back to 01, and a following valid command works.
  - length 8'h00: ERROR, then IDLE.
- Spurious events in IDLE and GET_ADDR:
  - `finish_flag` and `flash_done` pulses: no state change.
  - in WRITING_RAM, data byte 8'h57: no re-parse.
- Reset: assert `rst_n` = 0 during FLASH_WRITE. Required: immediate `status` = 01, all outputs 0, and a clean next command.
- With `UART_CMD_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 100: send 57 only, then idle.
  - Required: `cmd_err` at the 100th cycle after the byte, then IDLE.
  - Without the macro, `status` stays 02 indefinitely.

Source files
------------

// File: rtl/uart_cmd_controller.sv
// Command parser and flash sequencer for the UART-to-flash path: opcode/length/address
// header, then RAM pass and flash operation. Optional header timeout via UART_CMD_TIMEOUT_EN.
module uart_cmd_controller #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_flag,
  input  logic [7:0]  rx_data,
  input  logic        finish_flag,
  input  logic        flash_done,
  output logic [7:0]  status,
  output logic [7:0]  data_trans_length,
  output logic [15:0] flash_addr,
  output logic        flash_start,
  output logic        flash_wr,
  output logic        busy,
  output logic        cmd_err
);

  typedef enum logic [7:0] {
    IDLE        = 8'h01,
    GET_LEN     = 8'h02,
    GET_ADDR    = 8'h04,
    FLASH_READ  = 8'h08,
    WRITING_RAM = 8'h10,
    READING_RAM = 8'h20,
    FLASH_WRITE = 8'h40,
    ERROR       = 8'h80
  } state_t;

  state_t     state;
  logic       rxFlagD;
  logic       byteVld;
  logic [7:0] byteReg;
  logic       opWr;
  logic       byteCnt;
  logic       timeout;

  assign status = state;
  assign busy   = (state != IDLE);

  // Edge-detect stage: the byte is registered with its valid pulse, FSM acts one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxFlagD <= 1'b0;
      byteVld <= 1'b0;
      byteReg <= 8'h00;
    end else begin
      rxFlagD <= rx_flag;
      byteVld <= rx_flag & ~rxFlagD;
      byteReg <= rx_data;
    end
  end

`ifdef UART_CMD_TIMEOUT_EN
  logic [23:0] toCnt;
  logic        inHeader;
  assign inHeader = (state == GET_LEN) || (state == GET_ADDR);
  assign timeout  = inHeader && !byteVld && (toCnt == TIMEOUT_CYCLES - 24'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  toCnt <= 24'd0;
    else if (!inHeader || byteVld) toCnt <= 24'd0;
    else                         toCnt <= toCnt + 24'd1;
  end
`else
  // Counter compiled out; the parameter stays in the interface but never fires.
  assign timeout = 1'b0 & (^TIMEOUT_CYCLES);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      data_trans_length <= 8'h00;
      flash_addr        <= 16'h0000;
      flash_start       <= 1'b0;
      flash_wr          <= 1'b0;
      cmd_err           <= 1'b0;
      opWr              <= 1'b0;
      byteCnt           <= 1'b0;
    end else begin
      flash_start <= 1'b0;
      cmd_err     <= 1'b0;
      case (state)
        IDLE: if (byteVld) begin
          if (byteReg == 8'h57) begin
            opWr  <= 1'b1;
            state <= GET_LEN;
          end else if (byteReg == 8'h52) begin
            opWr  <= 1'b0;
            state <= GET_LEN;
          end else begin
            state   <= ERROR;
            cmd_err <= 1'b1;
          end
        end
        GET_LEN: if (byteVld) begin
          data_trans_length <= byteReg;
          byteCnt           <= 1'b0;
          if (byteReg == 8'h00) begin
            state   <= ERROR;
            cmd_err <= 1'b1;
          end else begin
            state <= GET_ADDR;
          end
        end else if (timeout) begin
          state   <= ERROR;
          cmd_err <= 1'b1;
        end
        GET_ADDR: if (byteVld) begin
          byteCnt <= ~byteCnt;
          if (!byteCnt) begin
            flash_addr[15:8] <= byteReg;
          end else begin
            flash_addr[7:0] <= byteReg;
            if (opWr) begin
              state <= WRITING_RAM;
            end else begin
              state       <= FLASH_READ;
              flash_start <= 1'b1;
              flash_wr    <= 1'b0;
            end
          end
        end else if (timeout) begin
          state   <= ERROR;
          cmd_err <= 1'b1;
        end
        WRITING_RAM: if (finish_flag) begin
          state       <= FLASH_WRITE;
          flash_start <= 1'b1;
          flash_wr    <= 1'b1;
        end
        FLASH_WRITE: if (flash_done) begin
          state    <= IDLE;
          flash_wr <= 1'b0;
        end
        FLASH_READ: if (flash_done) state <= READING_RAM;
        READING_RAM: if (finish_flag) state <= IDLE;
        ERROR: state <= IDLE;
        default: begin
          state    <= IDLE;
          flash_wr <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_controller.sv
// Directed bench for uart_cmd_controller: write/read commands, bad input, spurious events,
// mid-command reset and header timeout behaviour.
module tb_uart_cmd_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_flag;
  logic [7:0]  rx_data;
  logic        finish_flag;
  logic        flash_done;
  logic [7:0]  status;
  logic [7:0]  data_trans_length;
  logic [15:0] flash_addr;
  logic        flash_start;
  logic        flash_wr;
  logic        busy;
  logic        cmd_err;

  int nChecks = 0;
  int nPass   = 0;

  uart_cmd_controller #(.TIMEOUT_CYCLES(24'd100)) dut (
    .clk(clk), .rst_n(rst_n), .rx_flag(rx_flag), .rx_data(rx_data),
    .finish_flag(finish_flag), .flash_done(flash_done), .status(status),
    .data_trans_length(data_trans_length), .flash_addr(flash_addr),
    .flash_start(flash_start), .flash_wr(flash_wr), .busy(busy), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Returns at the negedge after the FSM has acted on the byte.
  task automatic sendByte(input logic [7:0] b);
    @(negedge clk); rx_data = b; rx_flag = 1'b1;
    @(negedge clk); rx_flag = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse(input logic fin, input logic done);
    @(negedge clk); finish_flag = fin; flash_done = done;
    @(negedge clk); finish_flag = 1'b0; flash_done = 1'b0;
  endtask

  task automatic chkIdle(input string tag);
    chk({tag, "_status"}, 16'(status), 16'h0001);
    chk({tag, "_busy"}, 16'(busy), 16'h0000);
  endtask

  initial begin
    rst_n = 1'b0; rx_flag = 1'b0; rx_data = 8'h00; finish_flag = 1'b0; flash_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_status", 16'(status), 16'h0001);
    chk("rst_len", 16'(data_trans_length), 16'h0000);
    chk("rst_addr", flash_addr, 16'h0000);
    chk("rst_start", 16'(flash_start), 16'h0000);
    chk("rst_wr", 16'(flash_wr), 16'h0000);
    chk("rst_busy", 16'(busy), 16'h0000);
    chk("rst_err", 16'(cmd_err), 16'h0000);
    rst_n = 1'b1;

    // Spurious events in IDLE
    pulse(1'b1, 1'b1);
    chkIdle("spur_idle");

    // Write command
    sendByte(8'h57); chk("wr_op_status", 16'(status), 16'h0002);
    chk("wr_op_busy", 16'(busy), 16'h0001);
    sendByte(8'h04); chk("wr_len_status", 16'(status), 16'h0004);
    chk("wr_len", 16'(data_trans_length), 16'h0004);
    sendByte(8'h12); chk("wr_a0_status", 16'(status), 16'h0004);
    pulse(1'b1, 1'b1); chk("spur_addr_status", 16'(status), 16'h0004);
    sendByte(8'h34); chk("wr_a1_status", 16'(status), 16'h0010);
    chk("wr_addr", flash_addr, 16'h1234);
    chk("wr_nostart", 16'(flash_start), 16'h0000);
    sendByte(8'h57); sendByte(8'hAA); sendByte(8'h00); sendByte(8'h52);
    chk("wr_data_noparse", 16'(status), 16'h0010);
    chk("wr_data_len", 16'(data_trans_length), 16'h0004);
    pulse(1'b0, 1'b1); chk("wr_spur_done", 16'(status), 16'h0010);
    pulse(1'b1, 1'b0);
    chk("wr_fw_status", 16'(status), 16'h0040);
    chk("wr_start_hi", 16'(flash_start), 16'h0001);
    chk("wr_wr_hi", 16'(flash_wr), 16'h0001);
    @(negedge clk);
    chk("wr_start_lo", 16'(flash_start), 16'h0000);
    chk("wr_wr_hold", 16'(flash_wr), 16'h0001);
    repeat (8) @(negedge clk);
    pulse(1'b0, 1'b1);
    chkIdle("wr_done");
    chk("wr_wr_clr", 16'(flash_wr), 16'h0000);
    chk("wr_addr_hold", flash_addr, 16'h1234);

    // Read command
    sendByte(8'h52); chk("rd_op_status", 16'(status), 16'h0002);
    sendByte(8'h10); chk("rd_len_status", 16'(status), 16'h0004);
    chk("rd_len", 16'(data_trans_length), 16'h0010);
    sendByte(8'h00); chk("rd_a0_status", 16'(status), 16'h0004);
    sendByte(8'h80);
    chk("rd_fr_status", 16'(status), 16'h0008);
    chk("rd_start_hi", 16'(flash_start), 16'h0001);
    chk("rd_wr_lo", 16'(flash_wr), 16'h0000);
    chk("rd_addr", flash_addr, 16'h0080);
    @(negedge clk);
    chk("rd_start_lo", 16'(flash_start), 16'h0000);
    pulse(1'b1, 1'b0); chk("rd_spur_fin", 16'(status), 16'h0008);
    pulse(1'b0, 1'b1); chk("rd_rr_status", 16'(status), 16'h0020);
    pulse(1'b1, 1'b0); chkIdle("rd_done");

    // Bad opcode
    sendByte(8'hAA);
    chk("badop_status", 16'(status), 16'h0080);
    chk("badop_err", 16'(cmd_err), 16'h0001);
    @(negedge clk);
    chk("badop_err_lo", 16'(cmd_err), 16'h0000);
    chkIdle("badop_back");
    sendByte(8'h52); sendByte(8'h01); sendByte(8'h00); sendByte(8'h01);
    chk("badop_next_status", 16'(status), 16'h0008);
    chk("badop_next_addr", flash_addr, 16'h0001);
    pulse(1'b0, 1'b1); pulse(1'b1, 1'b0);
    chkIdle("badop_next_done");

    // Zero length
    sendByte(8'h57); sendByte(8'h00);
    chk("len0_status", 16'(status), 16'h0080);
    chk("len0_err", 16'(cmd_err), 16'h0001);
    @(negedge clk);
    chkIdle("len0_back");
    chk("len0_err_lo", 16'(cmd_err), 16'h0000);

    // Reset during FLASH_WRITE
    sendByte(8'h57); sendByte(8'h02); sendByte(8'hAB); sendByte(8'hCD);
    pulse(1'b1, 1'b0);
    chk("rstw_pre_status", 16'(status), 16'h0040);
    #2 rst_n = 1'b0;
    #1;
    chk("rstw_status", 16'(status), 16'h0001);
    chk("rstw_start", 16'(flash_start), 16'h0000);
    chk("rstw_wr", 16'(flash_wr), 16'h0000);
    chk("rstw_busy", 16'(busy), 16'h0000);
    chk("rstw_len", 16'(data_trans_length), 16'h0000);
    chk("rstw_addr", flash_addr, 16'h0000);
    @(negedge clk); rst_n = 1'b1;
    sendByte(8'h57); chk("rstw_next_op", 16'(status), 16'h0002);
    sendByte(8'h01); sendByte(8'h00); sendByte(8'h05);
    chk("rstw_next_status", 16'(status), 16'h0010);
    chk("rstw_next_addr", flash_addr, 16'h0005);
    pulse(1'b1, 1'b0); pulse(1'b0, 1'b1);
    chkIdle("rstw_next_done");

    // Header timeout
    sendByte(8'h57);
`ifdef UART_CMD_TIMEOUT_EN
    begin
      int errAt = -1;
      for (int i = 1; i <= 150; i++) begin
        @(negedge clk);
        if (cmd_err && errAt < 0) errAt = i;
      end
      chk("to_seen", 16'(errAt >= 95 && errAt <= 102), 16'h0001);
      chkIdle("to_back");
    end
`else
    repeat (150) @(negedge clk);
    chk("to_hold_status", 16'(status), 16'h0002);
    chk("to_no_err", 16'(cmd_err), 16'h0000);
`endif

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
